// File: rtl/tdc_capture_pkg.sv
// tdc_pkg: shared types and helpers for the TDC capture stage.
// Holds the capture FSM state enum, the result-width helper and the
// thermometer first-zero search used by tdc_therm_enc.
package tdc_pkg;

    // Widest delay line the shared search function can handle.
    localparam int TDC_MAX_N = 256;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_SYNC   = 3'd2,
        ST_FILT   = 3'd3,
        ST_ENC    = 3'd4,
        ST_DONE   = 3'd5,
        ST_DRAIN  = 3'd6
    } tdc_cap_state_t;

    function automatic int tdc_res_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Index of the lowest zero among the first n bits; n when all are set.
    // Bits above the first zero never influence the answer.
    function automatic int therm_first_zero(input logic [TDC_MAX_N-1:0] v, input int n);
        int   res;
        logic found;
        res   = n;
        found = 1'b0;
        for (int i = 0; i < TDC_MAX_N; i++) begin
            if (!found && (i < n) && !v[i]) begin
                res   = i;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tdc_capture_if.sv
// tdc_capture_if: measurement control, delay-line sample and result handshake.
// slave is the capture block; master is the controller/consumer side.
interface tdc_capture_if #(
    parameter int N  = 64,
    parameter int CW = 16
);
    import tdc_pkg::*;
    localparam int RW = tdc_res_w(N);

    logic          arm_i;
    logic [N-1:0]  dl_i;
    logic          launch_o;
    logic [RW-1:0] result_o;
    logic          overflow_o;
    logic          valid_o;
    logic          ready_i;
    logic          busy_o;
    logic [CW-1:0] meas_cnt_o;

    modport slave (
        input  arm_i, dl_i, ready_i,
        output launch_o, result_o, overflow_o, valid_o, busy_o, meas_cnt_o
    );

    modport master (
        output arm_i, dl_i, ready_i,
        input  launch_o, result_o, overflow_o, valid_o, busy_o, meas_cnt_o
    );

endinterface

// File: rtl/tdc_capture_therm_enc.sv
// tdc_therm_enc: combinational thermometer-to-binary encoder.
// count = run length of ones from bit 0; overflow when every tap is set.
module tdc_therm_enc
    import tdc_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0]              therm,
    output logic [tdc_res_w(N)-1:0]   count,
    output logic                      overflow
);
    localparam int RW = tdc_res_w(N);

    // First-zero search; upper bits past the first zero are ignored.
    always_comb begin
        count    = RW'(therm_first_zero(TDC_MAX_N'(therm), N));
        overflow = &therm;
    end

endmodule

// File: rtl/tdc_capture.sv
// tdc_capture: launches the TDC edge, synchronizes the delay-line taps,
// encodes the frozen sample and hands it out over valid/ready.
// Optional macro TDC_BUBBLE_FILTER_EN adds a registered 3-tap majority
// filter and a FILT state (one extra cycle of latency).
//
// state  | meaning
// IDLE   | waiting for arm_i
// LAUNCH | edge travelling in the line, s1 captures the taps
// SYNC   | s2 holds the measurement
// FILT   | majority filter registering (filter build only)
// ENC    | encode sample, raise valid_o, drop launch_o
// DONE   | hold result until accepted
// DRAIN  | wait for the line to read all zeros before re-arming
module tdc_capture
    import tdc_pkg::*;
#(
    parameter int N  = 64,
    parameter int CW = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    tdc_capture_if.slave   bus
);
    localparam int RW = tdc_res_w(N);

    tdc_cap_state_t state;
    logic [N-1:0]   s1, s2;
    logic [N-1:0]   enc_in;
    logic [RW-1:0]  enc_count;
    logic           enc_ovf;

    logic           launch_q, valid_q, ovf_q, busy_q;
    logic [RW-1:0]  result_q;
    logic [CW-1:0]  cnt_q;

    // Free-running two-flop synchronizer on the asynchronous taps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.dl_i;
            s2 <= s1;
        end
    end

`ifdef TDC_BUBBLE_FILTER_EN
    logic [N-1:0]   filt;
    logic [N+1:0]   s2_ext;

    // Virtual tap below bit 0 reads one, virtual tap above the top reads zero.
    assign s2_ext = {1'b0, s2, 1'b1};

    // Registered majority of each tap and its two neighbours.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                filt[i] <= (s2_ext[i] & s2_ext[i+1]) | (s2_ext[i] & s2_ext[i+2]) |
                           (s2_ext[i+1] & s2_ext[i+2]);
            end
        end
    end

    assign enc_in = filt;
`else
    assign enc_in = s2;
`endif

    tdc_therm_enc #(.N(N)) u_enc (
        .therm    (enc_in),
        .count    (enc_count),
        .overflow (enc_ovf)
    );

    // Measurement sequencer with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            launch_q <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.arm_i) begin
                        state    <= ST_LAUNCH;
                        launch_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ST_LAUNCH: state <= ST_SYNC;
`ifdef TDC_BUBBLE_FILTER_EN
                ST_SYNC:   state <= ST_FILT;
                ST_FILT:   state <= ST_ENC;
`else
                ST_SYNC:   state <= ST_ENC;
`endif
                ST_ENC: begin
                    result_q <= enc_count;
                    ovf_q    <= enc_ovf;
                    valid_q  <= 1'b1;
                    launch_q <= 1'b0;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    if (valid_q && bus.ready_i) begin
                        valid_q <= 1'b0;
                        cnt_q   <= cnt_q + CW'(1);
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (s2 == '0) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    launch_q <= 1'b0;
                    valid_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.launch_o   = launch_q;
    assign bus.valid_o    = valid_q;
    assign bus.result_o   = result_q;
    assign bus.overflow_o = ovf_q;
    assign bus.busy_o     = busy_q;
    assign bus.meas_cnt_o = cnt_q;

endmodule

// File: tb/tb_tdc_capture.sv
// tb_tdc_capture: scoreboard bench for tdc_capture (CW=16 and CW=4 instances).
module tb_tdc_capture;
    import tdc_pkg::*;

    localparam int N  = 64;
    localparam int RW = tdc_res_w(N);
`ifdef TDC_BUBBLE_FILTER_EN
    localparam int LAT     = 4;
    localparam int BUB_RES = 16;
`else
    localparam int LAT     = 3;
    localparam int BUB_RES = 7;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdc_capture_if #(.N(N), .CW(16)) bus  ();
    tdc_capture_if #(.N(N), .CW(4))  bus4 ();

    assign bus4.arm_i   = bus.arm_i;
    assign bus4.dl_i    = bus.dl_i;
    assign bus4.ready_i = bus.ready_i;

    tdc_capture #(.N(N), .CW(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    tdc_capture #(.N(N), .CW(4)) dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus4.slave)
    );

    typedef struct {
        logic [RW-1:0] res;
        logic          ovf;
        int            arm_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   exp_cnt = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops an expectation whenever a new result is presented and
    // holds it against the outputs for as long as valid stays high.
    always @(negedge clk) begin
        if (bus.valid_o && !prev_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                cur = sb.pop_front();
                check("result", bus.result_o, cur.res);
                check("overflow", bus.overflow_o, cur.ovf);
                check("latency", cyc - cur.arm_cyc, LAT);
            end
        end else if (bus.valid_o && prev_valid) begin
            check("result_stable", bus.result_o, cur.res);
            check("overflow_stable", bus.overflow_o, cur.ovf);
        end
        prev_valid = bus.valid_o;
    end

    task automatic arm_with(input logic [N-1:0] pat, input bit push, input int er, input bit eo);
        exp_t e;
        bus.dl_i  = pat;
        bus.arm_i = 1'b1;
        if (push) begin
            e.res = RW'(er);
            e.ovf = eo;
            e.arm_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.arm_i = 1'b0;
        check("busy_after_arm", bus.busy_o, 1);
        check("launch_after_arm", bus.launch_o, 1);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.valid_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("valid_timeout", 0, 1);
    endtask

    task automatic accept(input int hold);
        for (int i = 0; i < hold; i++) begin
            bus.arm_i = (i % 3 == 0);
            @(negedge clk);
            check("valid_held", bus.valid_o, 1);
            check("cnt_no_incr", bus.meas_cnt_o, exp_cnt % 65536);
        end
        bus.arm_i   = 1'b0;
        bus.ready_i = 1'b1;
        @(negedge clk);
        exp_cnt++;
        check("valid_drop", bus.valid_o, 0);
        check("launch_low", bus.launch_o, 0);
        check("meas_cnt", bus.meas_cnt_o, exp_cnt % 65536);
        check("meas_cnt4", bus4.meas_cnt_o, exp_cnt % 16);
        check("busy_drain", bus.busy_o, 1);
    endtask

    task automatic drain(input int exp_edges);
        int n;
        bus.dl_i = '0;
        n = 0;
        while (bus.busy_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("drain_edges", n, exp_edges);
    endtask

    task automatic measure(input logic [N-1:0] pat, input int er, input bit eo,
                           input int hold, input int drain_delay);
        bit ok;
        bus.ready_i = (hold == 0);
        arm_with(pat, 1'b1, er, eo);
        wait_valid(ok);
        if (!ok) return;
        accept(hold);
        for (int i = 0; i < drain_delay; i++) begin
            @(negedge clk);
            check("busy_hold_drain", bus.busy_o, 1);
        end
        drain((pat == '0) ? 1 : 3);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_launch"}, bus.launch_o, 0);
        check({tag, "_valid"}, bus.valid_o, 0);
        check({tag, "_result"}, bus.result_o, 0);
        check({tag, "_overflow"}, bus.overflow_o, 0);
        check({tag, "_busy"}, bus.busy_o, 0);
        check({tag, "_cnt"}, bus.meas_cnt_o, 0);
        check({tag, "_cnt4"}, bus4.meas_cnt_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] p;
        bit           ok;
        bus.arm_i   = 1'b0;
        bus.dl_i    = '0;
        bus.ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        measure(64'h0000_0000_0000_FFFF, 16, 1'b0, 0, 0);
        measure('1, 64, 1'b1, 0, 0);
        measure('0, 0, 1'b0, 0, 0);
        measure(64'h0000_0000_0000_FF7F, BUB_RES, 1'b0, 0, 0);
        measure(64'h0000_0000_0000_0FFF, 12, 1'b0, 10, 5);
        measure(64'h0000_0000_0000_003F, 6, 1'b0, 0, 0);

        // Reset while in SYNC.
        bus.ready_i = 1'b0;
        arm_with(64'h0000_0000_0000_FFFF, 1'b0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        bus.dl_i = '0;
        @(negedge clk);
        check_reset_state("rst_sync");
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);

        // Reset while in DONE with a result pending.
        arm_with(64'h0000_0000_0000_00FF, 1'b1, 8, 1'b0);
        wait_valid(ok);
        @(negedge clk);
        rst = 1'b1;
        bus.dl_i = '0;
        @(negedge clk);
        check_reset_state("rst_done");
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);

        // 17 accepted results: CW=4 counter wraps to 1.
        for (int k = 0; k <= 16; k++) begin
            p = (64'h1 << k) - 64'h1;
            measure(p, k, 1'b0, 0, 0);
        end
        check("cnt_17", bus.meas_cnt_o, 17);
        check("cnt4_wrap", bus4.meas_cnt_o, 1);

        // Final re-arm after the wrap.
        measure(64'h0000_0000_00FF_FFFF, 24, 1'b0, 0, 0);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
